// File: rtl/jtag_id_pkg.sv
// Shared JTAG host definitions: IDCODE constants, host FSM states and the result payload.
package jtag_id_pkg;

  localparam int unsigned JTAG_IDCODE_LEN     = 32;
  localparam int unsigned JTAG_TLR_MIN_CYCLES = 5;

  localparam logic [JTAG_IDCODE_LEN-1:0] RV_DM_JTAG_IDCODE = 32'h1100_1CDF;

  typedef enum logic [2:0] {
    JhIdle,
    JhTlr,
    JhNav,
    JhShift,
    JhExit
  } jtag_host_state_e;

  typedef struct packed {
    logic [JTAG_IDCODE_LEN-1:0] idcode;
    logic                       match;
    logic                       marker_err;
  } jtag_id_result_t;

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: TckDiv clk cycles per half-period, with strobes marking the clk cycle whose
// closing edge raises or lowers TCK.
module jtag_tck_gen #(
  parameter int unsigned TckDiv = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clear_i,
  output logic tck_o,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned     CntW   = $clog2(TckDiv) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TckDiv - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [CntW-1:0] cnt_q;
  logic            wrap;

  assign wrap   = en_i && !clear_i && (cnt_q == CntMax);
  assign rise_c = wrap && !tck_o;
  assign fall_c = wrap && tck_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      tck_o <= 1'b0;
    end else if (clear_i) begin
      cnt_q <= '0;
      tck_o <= 1'b0;
    end else if (en_i) begin
      if (wrap) begin
        cnt_q <= '0;
        tck_o <= ~tck_o;
      end else begin
        cnt_q <= cnt_q + CntOne;
      end
    end
  end

endmodule

// File: rtl/jtag_idcode_reader.sv
// JTAG host that walks the target TAP to Shift-DR, shifts out the 32-bit IDCODE
// LSB-first and compares it against the expected value.
module jtag_idcode_reader
  import jtag_id_pkg::*;
#(
  parameter int unsigned                TckDiv         = 2,
  parameter int unsigned                TlrCycles      = JTAG_TLR_MIN_CYCLES,
  parameter logic [JTAG_IDCODE_LEN-1:0] ExpectedIdcode = RV_DM_JTAG_IDCODE
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic                       abort_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [JTAG_IDCODE_LEN-1:0] idcode_o,
  output logic                       match_o,
  output logic                       marker_err_o,
  output logic                       jtag_tck_o,
  output logic                       jtag_tms_o,
  output logic                       jtag_tdi_o,
  input  logic                       jtag_tdo_i
);

  localparam int unsigned EdgeW = 6;

  // Rising-edge indices (1-based) that end each phase or pick a TMS value.
  localparam logic [EdgeW-1:0] TlrLast   = EdgeW'(TlrCycles);
  localparam logic [EdgeW-1:0] NavSelDr  = EdgeW'(TlrCycles + 1);
  localparam logic [EdgeW-1:0] NavLast   = EdgeW'(TlrCycles + 4);
  localparam logic [EdgeW-1:0] ShiftPre  = EdgeW'(TlrCycles + 35);
  localparam logic [EdgeW-1:0] ShiftLast = EdgeW'(TlrCycles + 36);
  localparam logic [EdgeW-1:0] ExitUpd   = EdgeW'(TlrCycles + 37);
  localparam logic [EdgeW-1:0] TotalEdge = EdgeW'(TlrCycles + 38);
  localparam logic [EdgeW-1:0] EdgeOne   = EdgeW'(1);

  jtag_host_state_e           state_q, state_d;
  logic [EdgeW-1:0]           edge_q, edge_d, edge_inc;
  logic [JTAG_IDCODE_LEN-1:0] sr_q, sr_d;
  logic                       tms_q, tms_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  jtag_id_result_t            res_q, res_d;

  logic accept_c, abort_c, tck_rise, tck_fall, tck;

  assign accept_c = start_i && !busy_q;
  assign abort_c  = abort_i && busy_q;

  jtag_tck_gen #(
    .TckDiv(TckDiv)
  ) u_tck_gen (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (busy_q),
    .clear_i(accept_c || abort_c),
    .tck_o  (tck),
    .rise_c (tck_rise),
    .fall_c (tck_fall)
  );

  // Phase advance on TCK rise; next TMS value set up on TCK fall.
  always_comb begin
    state_d  = state_q;
    edge_d   = edge_q;
    sr_d     = sr_q;
    tms_d    = tms_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    res_d    = res_q;
    edge_inc = edge_q + EdgeOne;

    case (state_q)
      JhIdle: begin
        if (start_i) begin
          state_d = JhTlr;
          busy_d  = 1'b1;
          edge_d  = '0;
          tms_d   = 1'b1;
        end
      end
      JhTlr: begin
        if (tck_rise) begin
          edge_d = edge_inc;
          if (edge_inc == TlrLast) state_d = JhNav;
        end else if (tck_fall) begin
          tms_d = 1'b1;
        end
      end
      JhNav: begin
        if (tck_rise) begin
          edge_d = edge_inc;
          if (edge_inc == NavLast) state_d = JhShift;
        end else if (tck_fall) begin
          tms_d = (edge_q == NavSelDr);
        end
      end
      JhShift: begin
        if (tck_rise) begin
          edge_d = edge_inc;
          sr_d   = {jtag_tdo_i, sr_q[JTAG_IDCODE_LEN-1:1]};
          if (edge_inc == ShiftLast) state_d = JhExit;
        end else if (tck_fall) begin
          tms_d = (edge_q == ShiftPre);
        end
      end
      JhExit: begin
        if (tck_rise) begin
          edge_d = edge_inc;
        end else if (tck_fall) begin
          if (edge_q == TotalEdge) begin
            state_d          = JhIdle;
            busy_d           = 1'b0;
            tms_d            = 1'b1;
            done_d           = 1'b1;
            res_d.idcode     = sr_q;
            res_d.match      = (sr_q == ExpectedIdcode);
            res_d.marker_err = ~sr_q[0];
          end else begin
            tms_d = (edge_q != ExitUpd);
          end
        end
      end
      default: state_d = JhIdle;
    endcase

    // Abort leaves the TAP mid-sequence; the next TLR phase recovers it.
    if (abort_c) begin
      state_d = JhIdle;
      busy_d  = 1'b0;
      tms_d   = 1'b1;
      done_d  = 1'b0;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= JhIdle;
      edge_q  <= '0;
      sr_q    <= '0;
      tms_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
      sr_q    <= sr_d;
      tms_q   <= tms_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign idcode_o     = res_q.idcode;
  assign match_o      = res_q.match;
  assign marker_err_o = res_q.marker_err;
  assign jtag_tck_o   = tck;
  assign jtag_tms_o   = tms_q;
  assign jtag_tdi_o   = 1'b1;

endmodule

// File: tb/tb_jtag_idcode_reader.sv
// Directed bench: behavioural TAP target on the TckDiv=2 reader, TDO tied high on TckDiv=1/7 readers.
`timescale 1ns/1ps
module tb_jtag_idcode_reader;
  import jtag_id_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  start_v, abort_v, busy_v, done_v, tck_v, tms_v, tdi_v, match_v, merr_v;
  logic [31:0] idc0, idc1, idc2;
  logic        tdo0;

  int vectors = 0;
  int miscompares = 0;

  jtag_idcode_reader #(.TckDiv(2)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_v[0]), .abort_i(abort_v[0]),
    .busy_o(busy_v[0]), .done_o(done_v[0]), .idcode_o(idc0), .match_o(match_v[0]),
    .marker_err_o(merr_v[0]), .jtag_tck_o(tck_v[0]), .jtag_tms_o(tms_v[0]),
    .jtag_tdi_o(tdi_v[0]), .jtag_tdo_i(tdo0));

  jtag_idcode_reader #(.TckDiv(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_v[1]), .abort_i(abort_v[1]),
    .busy_o(busy_v[1]), .done_o(done_v[1]), .idcode_o(idc1), .match_o(match_v[1]),
    .marker_err_o(merr_v[1]), .jtag_tck_o(tck_v[1]), .jtag_tms_o(tms_v[1]),
    .jtag_tdi_o(tdi_v[1]), .jtag_tdo_i(1'b1));

  jtag_idcode_reader #(.TckDiv(7)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_v[2]), .abort_i(abort_v[2]),
    .busy_o(busy_v[2]), .done_o(done_v[2]), .idcode_o(idc2), .match_o(match_v[2]),
    .marker_err_o(merr_v[2]), .jtag_tck_o(tck_v[2]), .jtag_tms_o(tms_v[2]),
    .jtag_tdi_o(tdi_v[2]), .jtag_tdo_i(1'b1));

  // Behavioural TAP: IR is not modelled, the DR is always IDCODE.
  typedef enum logic [3:0] {
    TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUDR, EX2DR, UPDDR,
    SELIR, CAPIR, SHIR, EX1IR, PAUIR, EX2IR, UPDIR
  } tap_e;

  tap_e        tap_st = TLR;
  logic [31:0] tap_dr = '0;
  logic [31:0] tap_id = RV_DM_JTAG_IDCODE;
  logic        tap_tdo = 1'b0;
  int          tdo_mode = 0;

  function automatic tap_e tap_next(tap_e s, logic m);
    case (s)
      TLR:     return m ? TLR   : RTI;
      RTI:     return m ? SELDR : RTI;
      SELDR:   return m ? SELIR : CAPDR;
      CAPDR:   return m ? EX1DR : SHDR;
      SHDR:    return m ? EX1DR : SHDR;
      EX1DR:   return m ? UPDDR : PAUDR;
      PAUDR:   return m ? EX2DR : PAUDR;
      EX2DR:   return m ? UPDDR : SHDR;
      UPDDR:   return m ? SELDR : RTI;
      SELIR:   return m ? TLR   : CAPIR;
      CAPIR:   return m ? EX1IR : SHIR;
      SHIR:    return m ? EX1IR : SHIR;
      EX1IR:   return m ? UPDIR : PAUIR;
      PAUIR:   return m ? EX2IR : PAUIR;
      EX2IR:   return m ? UPDIR : SHIR;
      UPDIR:   return m ? SELDR : RTI;
      default: return TLR;
    endcase
  endfunction

  always @(posedge tck_v[0]) begin
    if (tap_st == CAPDR)     tap_dr <= tap_id;
    else if (tap_st == SHDR) tap_dr <= {tdi_v[0], tap_dr[31:1]};
    tap_st <= tap_next(tap_st, tms_v[0]);
  end

  always @(negedge tck_v[0]) tap_tdo <= (tap_st == SHDR) ? tap_dr[0] : 1'b0;

  assign tdo0 = (tdo_mode == 0) ? tap_tdo : (tdo_mode == 2);

  // TMS required at rising edge k of a run.
  function automatic logic exp_tms(int k);
    if (k <= 5) return 1'b1;
    if (k == 6) return 1'b0;
    if (k == 7) return 1'b1;
    if (k == 41 || k == 42) return 1'b1;
    return 1'b0;
  endfunction

  logic [2:0] mon_en    = 3'b111;
  logic [2:0] prev_tck  = '0;
  logic [2:0] prev_tms  = '1;
  logic [2:0] prev_busy = '0;
  int rise_cnt [3] = '{0, 0, 0};
  int tms_err  [3] = '{0, 0, 0};
  int viol     [3] = '{0, 0, 0};

  // Per-run edge/TMS table tracking and TMS-changes-only-on-TCK-fall watch.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      automatic int rc = rise_cnt[i];
      automatic int te = tms_err[i];
      if (busy_v[i] && !prev_busy[i]) begin
        rc = 0;
        te = 0;
      end
      if (tck_v[i] && !prev_tck[i]) begin
        rc++;
        if (tms_v[i] !== exp_tms(rc)) te++;
      end
      if (mon_en[i] && (tms_v[i] !== prev_tms[i]) && !(prev_tck[i] && !tck_v[i]))
        viol[i] <= viol[i] + 1;
      rise_cnt[i]  <= rc;
      tms_err[i]   <= te;
      prev_tck[i]  <= tck_v[i];
      prev_tms[i]  <= tms_v[i];
      prev_busy[i] <= busy_v[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulse start, run until done (bounded), then watch 20 more cycles for extra done pulses.
  task automatic run(input int sel, input int restart_at, input int budget,
                     output int busy_cyc, output int dones, output int period);
    int   cyc, r1, r2, nr;
    logic pt;
    bit   seen;
    busy_cyc = 0; dones = 0; period = 0;
    r1 = 0; r2 = 0; nr = 0; pt = 1'b0; seen = 1'b0; cyc = 0;
    @(negedge clk) start_v[sel] = 1'b1;
    @(negedge clk) start_v[sel] = 1'b0;
    while (!seen && cyc < budget) begin
      cyc++;
      if (busy_v[sel]) busy_cyc++;
      if (done_v[sel]) begin
        dones++;
        seen = 1'b1;
      end
      if (tck_v[sel] && !pt) begin
        nr++;
        if (nr == 1) r1 = cyc;
        if (nr == 2) r2 = cyc;
      end
      pt = tck_v[sel];
      start_v[sel] = (cyc == restart_at);
      if (!seen) @(negedge clk);
    end
    start_v[sel] = 1'b0;
    if (!seen) check("run_timeout", 32'd1, 32'd0);
    repeat (20) begin
      @(negedge clk);
      if (done_v[sel]) dones++;
    end
    period = r2 - r1;
  endtask

  initial begin
    int   bc, dn, per, nr, cyc;
    logic pt;

    rst_n = 1'b0; start_v = '0; abort_v = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",   32'(busy_v[0]), 32'd0);
    check("rst_done",   32'(done_v[0]), 32'd0);
    check("rst_idcode", idc0,           32'd0);
    check("rst_match",  32'(match_v[0]), 32'd0);
    check("rst_merr",   32'(merr_v[0]), 32'd0);
    check("rst_tck",    32'(tck_v[0]),  32'd0);
    check("rst_tms",    32'(tms_v[0]),  32'd1);
    check("rst_tdi",    32'(tdi_v[0]),  32'd1);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // rv_dm IDCODE through the TAP model
    tap_id = 32'h1100_1CDF; tdo_mode = 0;
    run(0, 0, 1000, bc, dn, per);
    check("t1_busy_cycles", bc, 172);
    check("t1_done_count",  dn, 1);
    check("t1_idcode",      idc0, 32'h1100_1CDF);
    check("t1_match",       32'(match_v[0]), 32'd1);
    check("t1_merr",        32'(merr_v[0]), 32'd0);
    check("t1_rises",       rise_cnt[0], 43);
    check("t1_tms_table",   tms_err[0], 0);
    check("t1_tck_period",  per, 4);

    tap_id = 32'h0BAD_C0DF;
    run(0, 0, 1000, bc, dn, per);
    check("t2_idcode", idc0, 32'h0BAD_C0DF);
    check("t2_match",  32'(match_v[0]), 32'd0);
    check("t2_merr",   32'(merr_v[0]), 32'd0);
    check("t2_done",   dn, 1);

    tdo_mode = 1;
    run(0, 0, 1000, bc, dn, per);
    check("t3_low_idcode", idc0, 32'h0000_0000);
    check("t3_low_match",  32'(match_v[0]), 32'd0);
    check("t3_low_merr",   32'(merr_v[0]), 32'd1);

    tdo_mode = 2;
    run(0, 0, 1000, bc, dn, per);
    check("t3_high_idcode", idc0, 32'hFFFF_FFFF);
    check("t3_high_match",  32'(match_v[0]), 32'd0);
    check("t3_high_merr",   32'(merr_v[0]), 32'd0);

    // Abort at rising edge 20, then a clean run
    tdo_mode = 0; tap_id = 32'h1100_1CDF;
    @(negedge clk) start_v[0] = 1'b1;
    @(negedge clk) start_v[0] = 1'b0;
    nr = 0; pt = 1'b0; cyc = 0; dn = 0;
    while (nr < 20 && cyc < 1000) begin
      cyc++;
      if (done_v[0]) dn++;
      if (tck_v[0] && !pt) nr++;
      pt = tck_v[0];
      if (nr < 20) @(negedge clk);
    end
    check("t4_reach_edge20", nr, 20);
    mon_en[0] = 1'b0;
    abort_v[0] = 1'b1;
    @(negedge clk) abort_v[0] = 1'b0;
    check("t4_abort_busy", 32'(busy_v[0]), 32'd0);
    check("t4_abort_tck",  32'(tck_v[0]),  32'd0);
    check("t4_abort_tms",  32'(tms_v[0]),  32'd1);
    repeat (20) begin
      @(negedge clk);
      if (done_v[0]) dn++;
    end
    check("t4_abort_no_done", dn, 0);
    check("t4_abort_idcode_kept", idc0, 32'hFFFF_FFFF);
    mon_en[0] = 1'b1;
    run(0, 0, 1000, bc, dn, per);
    check("t4_rerun_done",   dn, 1);
    check("t4_rerun_idcode", idc0, 32'h1100_1CDF);
    check("t4_rerun_match",  32'(match_v[0]), 32'd1);

    // Reset mid-SHIFT, then a run with a second start while busy
    @(negedge clk) start_v[0] = 1'b1;
    @(negedge clk) start_v[0] = 1'b0;
    nr = 0; pt = 1'b0; cyc = 0;
    while (nr < 25 && cyc < 1000) begin
      cyc++;
      if (tck_v[0] && !pt) nr++;
      pt = tck_v[0];
      if (nr < 25) @(negedge clk);
    end
    check("t5_reach_edge25", nr, 25);
    mon_en[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy",   32'(busy_v[0]), 32'd0);
    check("t5_rst_done",   32'(done_v[0]), 32'd0);
    check("t5_rst_tck",    32'(tck_v[0]),  32'd0);
    check("t5_rst_tms",    32'(tms_v[0]),  32'd1);
    check("t5_rst_idcode", idc0,           32'd0);
    check("t5_rst_match",  32'(match_v[0]), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    mon_en[0] = 1'b1;
    run(0, 60, 1000, bc, dn, per);
    check("t5_busy_cycles", bc, 172);
    check("t5_done_count",  dn, 1);
    check("t5_match",       32'(match_v[0]), 32'd1);
    check("t5_idcode",      idc0, 32'h1100_1CDF);

    // TckDiv = 1 and TckDiv = 7
    run(1, 0, 1000, bc, dn, per);
    check("t6_d1_busy",   bc, 86);
    check("t6_d1_period", per, 2);
    check("t6_d1_done",   dn, 1);
    check("t6_d1_idcode", idc1, 32'hFFFF_FFFF);
    check("t6_d1_rises",  rise_cnt[1], 43);
    check("t6_d1_tms",    tms_err[1], 0);

    run(2, 0, 2000, bc, dn, per);
    check("t6_d7_busy",   bc, 602);
    check("t6_d7_period", per, 14);
    check("t6_d7_done",   dn, 1);
    check("t6_d7_idcode", idc2, 32'hFFFF_FFFF);
    check("t6_d7_rises",  rise_cnt[2], 43);
    check("t6_d7_tms",    tms_err[2], 0);

    check("tms_fall_only_d2", viol[0], 0);
    check("tms_fall_only_d1", viol[1], 0);
    check("tms_fall_only_d7", viol[2], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
